// File: rtl/mux8_rr_select_scheduler.sv
// rtl/mux8_rr_select_scheduler.sv - round-robin select/grant scheduler for a shared 8-to-1 mux
module mux8_rr_select_scheduler #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       switch
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            switch_q, switch_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      last_q, last_d;

    logic [2:0]      win_idx;
    logic            win_found;
    logic [2:0]      scan_idx;
    logic            hold_done;
    logic            release_now;

    // Scan starts just past the previous owner so the previous owner comes last.
    always_comb begin
        win_idx   = 3'd0;
        win_found = 1'b0;
        scan_idx  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = last_q + 3'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign hold_done   = (count_q == CW'(HOLD_MAX));
    assign release_now = !en || !req[sel_q] || hold_done;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        switch_d = 1'b0;
        count_d  = count_q;
        last_d   = last_q;
        if (state_q == GRANT && !release_now) begin
            count_d = count_q + CW'(1);
        end else if (en && win_found) begin
            // Direct handoff from GRANT or a fresh grant from IDLE; never an idle bubble.
            state_d  = GRANT;
            sel_d    = win_idx;
            grant_d  = 8'b1 << win_idx;
            busy_d   = 1'b1;
            switch_d = 1'b1;
            count_d  = CW'(1);
            last_d   = win_idx;
        end else begin
            state_d = IDLE;
            grant_d = 8'h00;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            grant_q  <= 8'h00;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
            count_q  <= '0;
            last_q   <= 3'd7;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            switch_q <= switch_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    assign sel    = sel_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign switch = switch_q;

endmodule

// File: doc/mux8_rr_select_scheduler.md
Name: mux8_rr_select_scheduler

Overview:
- Round-robin scheduler that shares one 8-to-1 single-bit multiplexer among eight requesters.
- Drives the mux 3-bit select and a one-hot grant vector back to the requesters.
- Bounds each grant to HOLD_MAX cycles so no requester can starve the others.
- Sits between the requester bank and the mux select input. Purely control: no data passes through it.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles a single grant is held; legal range 1..15
CW, 4, width of the internal hold counter; must satisfy 2^CW > HOLD_MAX

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
en  input  1  scheduler enable; low forces release and blocks new grants
req  input  8  request vector; req[i] high = requester i wants the mux
sel  output  3  mux select (binary index of the granted requester)
grant  output  8  one-hot grant; all-zero when idle
busy  output  1  high while any grant is active
switch  output  1  one-cycle pulse in the first cycle of every new grant, including a re-grant to the same index

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All outputs are registered.
- rst high at an edge:
  - sel=0, grant=0, busy=0, switch=0.
  - Hold count=0, state=IDLE.
  - Round-robin pointer last=7, so the first search starts at index 0.
  - rst overrides everything, including a grant in progress; the grant drops on that edge.
- Priority search: scan indices (last+1) mod 8, (last+2) mod 8, ..., last, wrapping. Pick the first i with req[i]=1. The previous owner is therefore lowest priority.
- State IDLE:
  - If en=1 and any req bit is high at an edge: on that edge grant=1<<i, sel=i, busy=1, switch=1, count=1, last=i, go to GRANT.
  - Otherwise outputs hold: grant=0, busy=0, switch=0, sel keeps its previous value.
  - Latency from req asserted to grant visible is 1 cycle.
- State GRANT, evaluated each edge with current owner o=sel:
  - Release condition: en=0, OR req[o]=0, OR count==HOLD_MAX.
  - No release: count increments, grant/sel hold, switch=0.
  - Release with en=1 and a winner found by the search (from o+1, o itself last): direct handoff on the same edge. grant/sel take the new index, switch=1, count=1, last updated, state stays GRANT. No idle bubble.
  - Release with en=0, or no request found: go to IDLE. grant=0, busy=0, switch=0, sel unchanged.
- A sole continuous requester is re-granted immediately after HOLD_MAX expiry. Same sel, switch pulses again, count restarts at 1.
- HOLD_MAX=1: every grant lasts exactly one cycle and switch is high every active cycle.
- Simultaneous events:
  - en falling on the same edge a new request arrives: release wins, no grant.
  - Owner drops req on the same edge as hold expiry: one release, one handoff.
- sel changes only on edges where switch=1. sel always equals the index of the set grant bit while busy=1.
- Invariants: grant is one-hot or zero; busy == |grant.

Test Plan:
- Reset, then req=8'b0000_0001, en=1 (HOLD_MAX=4) -> 1 cycle later grant=8'h01, sel=0, switch=1 for 1 cycle. Same grant re-issued with switch=1 after 4 cycles.
- req=8'hFF held, HOLD_MAX=4 -> sel sequence 0,1,2,...,7,0, each held exactly 4 cycles. switch pulses every 4th cycle, busy never drops.
- Owner 3 granted, req=8'b0010_1000; drop req[3] after 2 cycles -> next edge grant=8'h20, sel=5, switch=1, no idle cycle.
- Owner 6 granted; drop all req -> next edge grant=0, busy=0, sel stays 6. Then req=8'h41 -> grant=8'h80? No: search starts at 7, so grant=8'h01, sel=0.
- During grant to 2, drive en=0 -> next edge grant=0, busy=0. Reassert en with req[2] still high -> re-grant index 2 with switch=1.
- Assert rst mid-grant (sel=5, count=3) -> same edge all outputs 0. Subsequent req=8'hFF grants index 0 first.
